// File: rtl/apb_master_q.sv
// apb_master_q: queued APB3 master.
// Commands enter a FIFO through a valid/ready handshake. The FSM issues them on
// the APB bus one at a time, decoding the slave from the top address bits. One
// response per command comes back, in order, through a response FIFO.
//
// Ports:
//   pclk, presetn              clock; synchronous active-high reset
//   cmd_valid/ready            command handshake (ready = command FIFO not full)
//   cmd_write/addr/wdata       command payload
//   rsp_valid/ready            response handshake (valid = response FIFO not empty)
//   rsp_rdata/err/timeout      response payload (rdata is 0 for writes and errors)
//   psel/penable/paddr/pwrite/pwdata   APB request signals
//   prdata/pready/pslverr      APB completion signals
//
// state  | meaning
// IDLE   | no transfer in flight; launches a command or retires a decode error
// SETUP  | psel asserted, penable low
// ACCESS | penable high, waiting for pready or timeout
module apb_master_q #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int NUM_SLV    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0]  cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic [NUM_SLV-1:0] psel,
  output logic               penable,
  output logic [ADDR_W-1:0]  paddr,
  output logic               pwrite,
  output logic [DATA_W-1:0]  pwdata,
  input  logic [DATA_W-1:0]  prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int SEL_W = $clog2(NUM_SLV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CMD_W = 1 + ADDR_W + DATA_W;
  localparam int RSP_W = DATA_W + 2;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SEL_W:0]   NSLV    = (SEL_W+1)'(NUM_SLV);
  localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W+2)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   PTR_ONE = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_nxt;

  // command FIFO
  logic [CMD_W-1:0] cmd_mem [FIFO_DEPTH];
  logic [PTR_W:0]   cmd_wp, cmd_rp;
  logic             cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic             h_write;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [SEL_W-1:0]  h_idx;
  logic              h_dec_ok;

  assign cmd_empty = (cmd_wp == cmd_rp);
  assign cmd_full  = (cmd_wp[PTR_W] != cmd_rp[PTR_W]) &&
                     (cmd_wp[PTR_W-1:0] == cmd_rp[PTR_W-1:0]);
  assign cmd_ready = !presetn && !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;
  assign {h_write, h_addr, h_wdata} = cmd_mem[cmd_rp[PTR_W-1:0]];
  assign h_idx     = h_addr[ADDR_W-1 -: SEL_W];
  assign h_dec_ok  = ({1'b0, h_idx} < NSLV);

  always_ff @(posedge pclk) begin
    if (cmd_push) cmd_mem[cmd_wp[PTR_W-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  // response FIFO
  logic [RSP_W-1:0] rsp_mem [FIFO_DEPTH];
  logic [PTR_W:0]   rsp_wp, rsp_rp, rsp_occ;
  logic [PTR_W+1:0] rsp_occ_nxt;
  logic [RSP_W-1:0] rsp_head;
  logic             rsp_push, rsp_pop, xfer_done, launch_ok;
  logic [DATA_W-1:0] push_rdata;
  logic             push_err, push_to;

  assign rsp_valid = (rsp_wp != rsp_rp);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_occ   = rsp_wp - rsp_rp;
  assign rsp_head  = rsp_mem[rsp_rp[PTR_W-1:0]];
  assign rsp_rdata   = rsp_valid ? rsp_head[RSP_W-1:2] : '0;
  assign rsp_err     = rsp_valid && rsp_head[1];
  assign rsp_timeout = rsp_valid && rsp_head[0];

  always_ff @(posedge pclk) begin
    if (rsp_push) rsp_mem[rsp_wp[PTR_W-1:0]] <= {push_rdata, push_err, push_to};
  end

  // A new command may only start if its eventual response already has a slot,
  // counting this cycle's completion push and consumer pop.
  assign xfer_done   = (state == ACCESS) && pready;
  assign rsp_occ_nxt = {1'b0, rsp_occ} + {{(PTR_W+1){1'b0}}, xfer_done}
                                       - {{(PTR_W+1){1'b0}}, rsp_pop};
  assign launch_ok   = !cmd_empty && (rsp_occ_nxt < DEPTH_L);

  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             load;

  // state register
  always_ff @(posedge pclk) begin
    if (presetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // next state, FIFO control and response payload
  always_comb begin
    state_nxt  = state;
    cmd_pop    = 1'b0;
    load       = 1'b0;
    rsp_push   = 1'b0;
    push_rdata = '0;
    push_err   = 1'b0;
    push_to    = 1'b0;
    case (state)
      IDLE: begin
        if (launch_ok) begin
          cmd_pop = 1'b1;
          if (h_dec_ok) begin
            load      = 1'b1;
            state_nxt = SETUP;
          end else begin
            rsp_push = 1'b1;
            push_err = 1'b1;
          end
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (pready) begin
          rsp_push   = 1'b1;
          push_rdata = (pwrite || pslverr) ? '0 : prdata;
          push_err   = pslverr;
          if (launch_ok && h_dec_ok) begin
            cmd_pop   = 1'b1;
            load      = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end else if (TIMEOUT != 0 && wait_cnt == TO_LAST) begin
          rsp_push  = 1'b1;
          push_err  = 1'b1;
          push_to   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // APB output and wait counter next values
  logic [NUM_SLV-1:0] psel_nxt;
  logic               penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0]  paddr_nxt;
  logic [DATA_W-1:0]  pwdata_nxt;

  always_comb begin
    psel_nxt     = psel;
    penable_nxt  = penable;
    paddr_nxt    = paddr;
    pwrite_nxt   = pwrite;
    pwdata_nxt   = pwdata;
    wait_cnt_nxt = wait_cnt;
    if (load) begin
      psel_nxt     = NUM_SLV'(1) << h_idx;
      penable_nxt  = 1'b0;
      paddr_nxt    = h_addr;
      pwrite_nxt   = h_write;
      pwdata_nxt   = h_write ? h_wdata : '0;
      wait_cnt_nxt = '0;
    end else if (state == SETUP) begin
      penable_nxt = 1'b1;
    end else if (state == ACCESS && state_nxt == IDLE) begin
      psel_nxt    = '0;
      penable_nxt = 1'b0;
      paddr_nxt   = '0;
      pwrite_nxt  = 1'b0;
      pwdata_nxt  = '0;
    end else if (state == ACCESS && !pready && TIMEOUT != 0) begin
      wait_cnt_nxt = wait_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge pclk) begin
    if (presetn) begin
      psel     <= '0;
      penable  <= 1'b0;
      paddr    <= '0;
      pwrite   <= 1'b0;
      pwdata   <= '0;
      wait_cnt <= '0;
      cmd_wp   <= '0;
      cmd_rp   <= '0;
      rsp_wp   <= '0;
      rsp_rp   <= '0;
    end else begin
      psel     <= psel_nxt;
      penable  <= penable_nxt;
      paddr    <= paddr_nxt;
      pwrite   <= pwrite_nxt;
      pwdata   <= pwdata_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (cmd_push) cmd_wp <= cmd_wp + PTR_ONE;
      if (cmd_pop)  cmd_rp <= cmd_rp + PTR_ONE;
      if (rsp_push) rsp_wp <= rsp_wp + PTR_ONE;
      if (rsp_pop)  rsp_rp <= rsp_rp + PTR_ONE;
    end
  end

endmodule

// File: tb/tb_apb_master_q.sv
// Directed testbench for apb_master_q with default parameters
// (ADDR_W 8, DATA_W 32, NUM_SLV 3, FIFO_DEPTH 4, TIMEOUT 16).
module tb_apb_master_q;

  logic        pclk = 1'b0;
  logic        presetn = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready = 1'b1;
  logic        pslverr = 1'b0;
  logic        use_fixed = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // slave read data: fixed pattern for one test, otherwise derived from paddr
  assign prdata = use_fixed ? 32'h12345678 : {24'hA5A5A5, paddr};

  apb_master_q dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // bus monitor, sampled at the active edge with pre-edge values
  logic mon_en = 1'b0;
  logic prev_done = 1'b0;
  logic saw_full = 1'b0;
  int   xfer_cnt = 0;
  int   chain_cnt = 0;
  always @(posedge pclk) begin
    if (mon_en) begin
      if (prev_done && psel != 3'b000 && !penable) chain_cnt++;
      if (penable && pready) xfer_cnt++;
      prev_done = penable && pready;
      if (!cmd_ready) saw_full = 1'b1;
    end
  end

  logic [7:0] b2b_addr [6] = '{8'h01, 8'h42, 8'h83, 8'h04, 8'h45, 8'h86};

  // Offers one command starting at a negedge; returns at the negedge after it is accepted.
  task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin @(negedge pclk); n++; end
    if (!cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_accept: cmd_ready got %b want 1 (addr %h)", cmd_ready, a);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge pclk);
    vectors++; if (psel !== 3'b000) begin miscompares++; $display("FAIL rst_psel: got %b want 000", psel); end
    vectors++; if (penable !== 1'b0) begin miscompares++; $display("FAIL rst_penable: got %b want 0", penable); end
    vectors++; if ({paddr, pwrite, pwdata} !== 41'd0) begin miscompares++; $display("FAIL rst_apb: got %h %b %h want 0", paddr, pwrite, pwdata); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if ({rsp_rdata, rsp_err, rsp_timeout} !== 34'd0) begin miscompares++; $display("FAIL rst_rsp: got %h %b %b want 0", rsp_rdata, rsp_err, rsp_timeout); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    presetn = 1'b0;
    @(negedge pclk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rel_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    pready = 1'b1;
    send(1'b1, 8'h45, 32'hDEADBEEF);
    vectors++; if (psel !== 3'b000) begin miscompares++; $display("FAIL wr_psel_e0: got %b want 000", psel); end
    @(negedge pclk);
    vectors++; if (psel !== 3'b010 || penable !== 1'b0) begin miscompares++; $display("FAIL wr_setup: psel %b pen %b want 010 0", psel, penable); end
    vectors++; if (paddr !== 8'h45 || pwrite !== 1'b1 || pwdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_setup_bus: got %h %b %h want 45 1 deadbeef", paddr, pwrite, pwdata); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_early: got %b want 0", rsp_valid); end
    @(negedge pclk);
    vectors++; if (psel !== 3'b010 || penable !== 1'b1 || pwdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_access: psel %b pen %b pwdata %h", psel, penable, pwdata); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_early2: got %b want 0", rsp_valid); end
    @(negedge pclk);
    vectors++; if (psel !== 3'b000 || penable !== 1'b0) begin miscompares++; $display("FAIL wr_idle: psel %b pen %b want 000 0", psel, penable); end
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL wr_rsp_valid: got %b want 1", rsp_valid); end
    vectors++; if ({rsp_rdata, rsp_err, rsp_timeout} !== 34'd0) begin miscompares++; $display("FAIL wr_rsp: got %h %b %b want 0 0 0", rsp_rdata, rsp_err, rsp_timeout); end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_pop: got %b want 0", rsp_valid); end
  endtask

  task automatic test_wait();
    pready = 1'b0; use_fixed = 1'b1;
    send(1'b0, 8'h82, 32'hFFFFFFFF);
    @(negedge pclk);
    vectors++; if (psel !== 3'b100 || pwrite !== 1'b0 || pwdata !== 32'd0) begin miscompares++; $display("FAIL rd_setup: psel %b pwrite %b pwdata %h", psel, pwrite, pwdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      vectors++; if (penable !== 1'b1 || psel !== 3'b100 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_access%0d: pen %b psel %b rsp_valid %b", i, penable, psel, rsp_valid); end
    end
    pready = 1'b1;
    @(negedge pclk);
    vectors++; if (penable !== 1'b0 || psel !== 3'b000) begin miscompares++; $display("FAIL rd_idle: pen %b psel %b", penable, psel); end
    vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL rd_rsp: valid %b rdata %h err %b want 1 12345678 0", rsp_valid, rsp_rdata, rsp_err); end
    use_fixed = 1'b0;
    rsp_ready = 1'b1; @(negedge pclk); rsp_ready = 1'b0;
  endtask

  task automatic test_decode();
    pready = 1'b1;
    send(1'b1, 8'hC0, 32'h11111111);
    vectors++; if (psel !== 3'b000) begin miscompares++; $display("FAIL dec_psel0: got %b want 000", psel); end
    @(negedge pclk);
    vectors++; if (psel !== 3'b000 || penable !== 1'b0) begin miscompares++; $display("FAIL dec_psel1: psel %b pen %b", psel, penable); end
    vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'd0) begin miscompares++; $display("FAIL dec_rsp: valid %b err %b to %b rdata %h want 1 1 0 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    rsp_ready = 1'b1; @(negedge pclk); rsp_ready = 1'b0;
    vectors++; if (psel !== 3'b000 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL dec_after: psel %b rsp_valid %b", psel, rsp_valid); end
  endtask

  task automatic test_slverr();
    pready = 1'b1; pslverr = 1'b1;
    send(1'b0, 8'h10, 32'h0);
    repeat (3) @(negedge pclk);
    vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'd0) begin miscompares++; $display("FAIL slverr_rsp: valid %b err %b to %b rdata %h want 1 1 0 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    pslverr = 1'b0;
    rsp_ready = 1'b1; @(negedge pclk); rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    pready = 1'b0;
    send(1'b0, 8'h80, 32'h0);
    repeat (17) @(negedge pclk);
    vectors++; if (penable !== 1'b1 || psel !== 3'b100 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL to_last_wait: pen %b psel %b rsp_valid %b want 1 100 0", penable, psel, rsp_valid); end
    @(negedge pclk);
    vectors++; if (psel !== 3'b000 || penable !== 1'b0) begin miscompares++; $display("FAIL to_abort_bus: psel %b pen %b want 000 0", psel, penable); end
    vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'd0) begin miscompares++; $display("FAIL to_rsp: valid %b err %b to %b rdata %h want 1 1 1 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    pready = 1'b1;
    rsp_ready = 1'b1; @(negedge pclk); rsp_ready = 1'b0;
  endtask

  task automatic test_chain();
    pready = 1'b1; rsp_ready = 1'b1;
    xfer_cnt = 0; chain_cnt = 0; prev_done = 1'b0; mon_en = 1'b1;
    for (int i = 0; i < 3; i++) send(1'b1, b2b_addr[i], 32'h100 + i);
    repeat (12) @(negedge pclk);
    mon_en = 1'b0;
    vectors++; if (xfer_cnt !== 3) begin miscompares++; $display("FAIL chain_xfers: got %0d want 3", xfer_cnt); end
    vectors++; if (chain_cnt !== 2) begin miscompares++; $display("FAIL chain_no_idle: got %0d want 2", chain_cnt); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL chain_drained: rsp_valid %b want 0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    pready = 1'b0; rsp_ready = 1'b0;
    xfer_cnt = 0; chain_cnt = 0; prev_done = 1'b0; saw_full = 1'b0; mon_en = 1'b1;
    fork
      begin for (int i = 0; i < 6; i++) send(1'b0, b2b_addr[i], 32'h0); end
      begin repeat (8) @(negedge pclk); pready = 1'b1; end
    join
    repeat (12) @(negedge pclk);
    vectors++; if (xfer_cnt !== 4) begin miscompares++; $display("FAIL b2b_xfers: got %0d want 4", xfer_cnt); end
    vectors++; if (chain_cnt !== 3) begin miscompares++; $display("FAIL b2b_chain: got %0d want 3", chain_cnt); end
    vectors++; if (saw_full !== 1'b1) begin miscompares++; $display("FAIL b2b_cmd_full: saw cmd_ready low %b want 1", saw_full); end
    vectors++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b1 || psel !== 3'b000) begin miscompares++; $display("FAIL b2b_stalled: rsp_valid %b cmd_ready %b psel %b", rsp_valid, cmd_ready, psel); end
    rsp_ready = 1'b1;
    for (int c = 0; c < 60 && k < 6; c++) begin
      if (rsp_valid) begin
        vectors++;
        if (rsp_rdata !== {24'hA5A5A5, b2b_addr[k]} || rsp_err !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_rsp%0d: rdata %h err %b want %h 0", k, rsp_rdata, rsp_err, {24'hA5A5A5, b2b_addr[k]});
        end
        k++;
      end
      @(negedge pclk);
    end
    mon_en = 1'b0;
    vectors++; if (k !== 6) begin miscompares++; $display("FAIL b2b_rsp_count: got %0d want 6", k); end
    vectors++; if (xfer_cnt !== 6) begin miscompares++; $display("FAIL b2b_xfers_total: got %0d want 6", xfer_cnt); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty: rsp_valid %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    rsp_ready = 1'b1; pready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, b2b_addr[i], 32'hCAFE0000 + i);
    vectors++; if (penable !== 1'b1) begin miscompares++; $display("FAIL mid_in_access: pen %b want 1", penable); end
    presetn = 1'b1;
    @(negedge pclk);
    vectors++; if ({psel, penable, paddr, pwrite, pwdata} !== 45'd0) begin miscompares++; $display("FAIL mid_apb_zero: psel %b pen %b addr %h wr %b wd %h", psel, penable, paddr, pwrite, pwdata); end
    vectors++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rsp_cmd: rsp_valid %b cmd_ready %b want 0 0", rsp_valid, cmd_ready); end
    presetn = 1'b0; pready = 1'b1;
    repeat (12) begin
      @(negedge pclk);
      if (rsp_valid || psel != 3'b000) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL mid_stale: active cycles %0d want 0", bad); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_cmd_ready: got %b want 1", cmd_ready); end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait();
    test_decode();
    test_slverr();
    test_timeout();
    test_chain();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
